// File: rtl/key_pkg.sv
// Shared types and default timing for the per-key conditioner.
// The board controller top level reuses the defaults when it builds one conditioner per key.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } key_state_t;

  localparam int KEY_DEBOUNCE_CYCLES = 4;
  localparam int KEY_REPEAT_DELAY    = 10;
  localparam int KEY_REPEAT_RATE     = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key level in, clean event pulses out. "release" is a reserved word in
// SystemVerilog, so the release pulse is carried as release_p.
interface key_conditioner_if;
  logic key_in;
  logic level;
  logic press;
  logic release_p;
  logic repeat_p;

  modport master (output key_in, input level, press, release_p, repeat_p);
  modport slave  (input key_in, output level, press, release_p, repeat_p);
endinterface

// File: rtl/key_conditioner.sv
// Debounces one synchronized key level and emits single-cycle press, release
// and auto-repeat pulses. All outputs are registered.
module key_conditioner
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY,
  parameter int REPEAT_RATE     = KEY_REPEAT_RATE,
  parameter int ACTIVE_LOW      = 0
) (
  input logic              clk,
  input logic              reset,
  key_conditioner_if.slave kif
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             raw;

  assign raw     = kif.key_in ^ (ACTIVE_LOW != 0);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = DB_PRESS;
            cnt_d   = CNT_ONE;
          end
        end
      end
      DB_PRESS: begin
        if (!raw) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!raw) begin
          // A one-sample debounce accepts the release on the first low sample.
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = DB_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end else if (REPEAT_DELAY != 0 && cnt_q == DELAY_LAST) begin
          state_d  = REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else if (REPEAT_DELAY != 0) begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (!raw) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = DB_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end else if (cnt_q == RATE_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DB_RELEASE: begin
        // A bounce back to 1 restarts the full repeat delay, not the rate.
        if (raw) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign kif.level     = level_q;
  assign kif.press     = press_q;
  assign kif.release_p = release_q;
  assign kif.repeat_p  = repeat_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulses with
// their edge index, a negedge monitor matches every pulse the DUTs emit.
module tb_key_conditioner;
  import key_pkg::*;

  localparam logic [2:0] P_PRESS = 3'b100;
  localparam logic [2:0] P_REL   = 3'b010;
  localparam logic [2:0] P_REP   = 3'b001;

  typedef struct {
    int         dut;
    int         cyc;
    logic [2:0] pulses;
    logic       level;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  key_conditioner_if if_a ();
  key_conditioner_if if_b ();

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .reset(reset), .kif(if_a.slave)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(3), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .reset(reset), .kif(if_b.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic expect_pulse(input int d, input int cyc, input logic [2:0] p);
    exp_t e;
    e.dut    = d;
    e.cyc    = cyc;
    e.pulses = p;
    e.level  = (p != P_REL);
    exp_q.push_back(e);
  endtask

  function automatic int first_idx(input int d);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].dut == d) return i;
    return -1;
  endfunction

  task automatic mon(input int d, input logic [2:0] p, input logic lv);
    int idx;
    idx = first_idx(d);
    while (idx >= 0 && exp_q[idx].cyc < edge_n) begin
      check($sformatf("missed_pulse_dut%0d", d), edge_n, exp_q[idx].cyc);
      exp_q.delete(idx);
      idx = first_idx(d);
    end
    if (p != 3'b000) begin
      if (idx < 0) begin
        check($sformatf("unexpected_pulse_dut%0d", d), int'(p), 0);
      end else begin
        check($sformatf("pulse_edge_dut%0d", d), edge_n, exp_q[idx].cyc);
        check($sformatf("pulse_kind_dut%0d", d), int'(p), int'(exp_q[idx].pulses));
        check($sformatf("pulse_level_dut%0d", d), int'(lv), int'(exp_q[idx].level));
        exp_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, {if_a.press, if_a.release_p, if_a.repeat_p}, if_a.level);
      mon(1, {if_b.press, if_b.release_p, if_b.repeat_p}, if_b.level);
    end
  end

  task automatic step(input logic ka, input logic kb, input int n);
    repeat (n) begin
      if_a.key_in = ka;
      if_b.key_in = kb;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    reset       = 1'b0;
    if_a.key_in = 1'b0;
    if_b.key_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs_a", int'({if_a.level, if_a.press, if_a.release_p, if_a.repeat_p}), 0);
    check("reset_outputs_b", int'({if_b.level, if_b.press, if_b.release_p, if_b.repeat_p}), 0);
    reset = 1'b1;
    step(1'b0, 1'b1, 2);

    // Press glitch: three high samples are not enough.
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 1);
    check("glitch_level", int'(if_a.level), 0);
    check("glitch_state", int'(dut_a.state_q), int'(IDLE));
    step(1'b0, 1'b1, 3);

    // Clean hold for 25 edges, then a clean release.
    t = edge_n + 1;
    expect_pulse(0, t + 3,  P_PRESS);
    expect_pulse(0, t + 13, P_REP);
    expect_pulse(0, t + 16, P_REP);
    expect_pulse(0, t + 19, P_REP);
    expect_pulse(0, t + 22, P_REP);
    step(1'b1, 1'b1, 25);
    check("hold_level", int'(if_a.level), 1);
    expect_pulse(0, t + 28, P_REL);
    step(1'b0, 1'b1, 4);
    check("release_level", int'(if_a.level), 0);
    step(1'b0, 1'b1, 12);

    // Release bounce: two low samples then high again restarts the delay.
    t = edge_n + 1;
    expect_pulse(0, t + 3,  P_PRESS);
    expect_pulse(0, t + 13, P_REP);
    step(1'b1, 1'b1, 16);
    step(1'b0, 1'b1, 2);
    check("bounce_level", int'(if_a.level), 1);
    expect_pulse(0, t + 28, P_REP);
    expect_pulse(0, t + 31, P_REP);
    step(1'b1, 1'b1, 14);
    expect_pulse(0, t + 35, P_REL);
    step(1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 6);

    // Asynchronous reset while a repeat pulse is high, key stays held.
    t = edge_n + 1;
    expect_pulse(0, t + 3,  P_PRESS);
    expect_pulse(0, t + 13, P_REP);
    step(1'b1, 1'b1, 14);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({if_a.level, if_a.press, if_a.release_p, if_a.repeat_p}), 0);
    check("async_reset_state", int'(dut_a.state_q), int'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    t = edge_n + 1;
    expect_pulse(0, t + 3, P_PRESS);
    step(1'b1, 1'b1, 6);
    expect_pulse(0, t + 9, P_REL);
    step(1'b0, 1'b1, 4);
    step(1'b0, 1'b1, 4);

    // Active-low key with auto-repeat disabled.
    t = edge_n + 1;
    expect_pulse(1, t + 3, P_PRESS);
    step(1'b0, 1'b0, 34);
    check("b_hold_level", int'(if_b.level), 1);
    expect_pulse(1, t + 37, P_REL);
    step(1'b0, 1'b1, 4);
    check("b_release_level", int'(if_b.level), 0);
    step(1'b0, 1'b1, 4);

    check("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Consumes the synchronized key/switch level produced by the two-flop synchronizer stage.
- Emits clean, single-cycle user events for the Sudoku board controller: press, release and auto-repeat.
- Cursor moves and digit selection act on these pulses, never on the raw level.
- One instance per key. The synchronizer stays outside this block.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical samples needed to accept a level change; legal range >= 1.
- REPEAT_DELAY, 10, cycles from the press pulse to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_RATE, 3, cycles between successive repeat pulses; legal range >= 1.
- ACTIVE_LOW, 0, 1 inverts key_in (DE1 KEY buttons read 0 when pressed).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset; 0 forces reset immediately.
- key_in  input  1  synchronized key level from the synchronizer.
- level  output  1  debounced pressed state.
- press  output  1  one-cycle pulse on an accepted press.
- release  output  1  one-cycle pulse on an accepted release.
- repeat_p  output  1  one-cycle pulse for each auto-repeat tick while held.

Behaviour:
- raw = key_in XOR ACTIVE_LOW, sampled on each posedge clk.
- All outputs are registered. Outputs change on the clock edge on which the transition is taken.
- Reset (reset==0, asynchronous):
  - state=IDLE, counter=0, level=0, press=0, release=0, repeat_p=0.
  - Deassertion takes effect on the next posedge.
  - No press is suppressed after reset: a key held through reset gets a full debounce and then a press pulse.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1). The counter saturates and never wraps.
- States:
  - IDLE:
    - raw=1: go to DB_PRESS, cnt=1.
    - If DEBOUNCE_CYCLES==1, go straight to HELD instead (press=1, level=1).
  - DB_PRESS:
    - raw=0: back to IDLE, cnt=0. This is glitch rejection; no outputs change.
    - raw=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, cnt=0, level=1, press=1 for exactly one cycle.
    - Otherwise cnt++.
  - HELD:
    - raw=0: go to DB_RELEASE, cnt=1. level stays 1.
    - REPEAT_DELAY!=0 and cnt==REPEAT_DELAY-1: go to REPEAT, cnt=0, repeat_p=1.
    - Otherwise cnt++. With REPEAT_DELAY==0 the counter holds.
  - REPEAT:
    - raw=0: go to DB_RELEASE, cnt=1.
    - cnt==REPEAT_RATE-1: repeat_p=1, cnt=0.
    - Otherwise cnt++.
  - DB_RELEASE:
    - raw=1: back to HELD, cnt=0. This is release-bounce rejection; repeat timing restarts at REPEAT_DELAY.
    - raw=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, level=0, release=1 for one cycle.
    - Otherwise cnt++.
- Pulse timing:
  - Press latency: press and level rise on the edge sampling the DEBOUNCE_CYCLES-th consecutive raw=1.
  - First repeat: REPEAT_DELAY cycles after the press pulse.
  - Subsequent repeats: every REPEAT_RATE cycles.
- Mutual exclusion: press, release and repeat_p are never high in the same cycle. No pulse lasts more than one cycle.
- No repeat_p is generated in DB_RELEASE, even if the rate counter would have expired.
- Reset mid-operation aborts any pending pulse. No release pulse is produced for a key that was held at reset.

Decomposition:
- Shared package key_pkg:
  - typedef enum logic [2:0] key_state_t {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE}.
  - Default constants KEY_DEBOUNCE_CYCLES, KEY_REPEAT_DELAY, KEY_REPEAT_RATE, reused by the board controller top level.
- Single module, no sub-modules. The top level instantiates synchronizer -> key_conditioner per key.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, ACTIVE_LOW=0 unless stated; cycle 0 = first edge sampling raw=1):
1. Press glitch: raw=1 for 3 edges then 0 -> press never asserts, level=0, state back to IDLE.
2. Clean hold: raw=1 held for 25 edges -> press=1 and level=1 at cycle 3 only; repeat_p=1 at cycles 13, 16, 19, 22; no other pulses.
3. Release bounce: hold to cycle 15, raw=0 for 2 edges, then raw=1 -> no release, level stays 1; next repeat_p exactly 10 cycles after re-entering HELD.
4. Clean release: after a hold, raw=0 for 4 edges -> release=1 and level=0 on the 4th edge; no repeat_p afterwards.
5. Async reset mid-hold: drive reset=0 between edges while level=1 -> all outputs 0 immediately. Deassert with raw=1 held -> press pulse on the 4th following edge.
6. ACTIVE_LOW=1, REPEAT_DELAY=0: key_in=0 for 4 edges -> press=1; hold 30 edges -> repeat_p stays 0; key_in=1 for 4 edges -> release=1.
